// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer: round-robin green/yellow/all-red per direction, pedestrian
// walk phase after a completed rotation, and a maintenance yellow flash override.
module traffic_light_ctrl #(
    parameter int NUM_DIR    = 2,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 4,
    parameter int MIN_GREEN  = 3,
    parameter int FLASH_CYC  = 2,
    parameter int CNT_W      = 8,
    localparam int DIR_W     = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   flash_mode,
    input  logic                   ped_req,
    output logic [3*NUM_DIR-1:0]   light,
    output logic                   walk,
    output logic [DIR_W-1:0]       active_dir,
    output logic                   ped_pending
);

    function automatic bit dwell_ok(input int v);
        return (v >= 1) && (longint'(v) <= (longint'(1) << CNT_W));
    endfunction

    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
        $error("traffic_light_ctrl: NUM_DIR must be in 2..8");
    end
    if (!dwell_ok(GREEN_CYC) || !dwell_ok(YELLOW_CYC) || !dwell_ok(ALLRED_CYC) ||
        !dwell_ok(WALK_CYC) || !dwell_ok(MIN_GREEN) || !dwell_ok(FLASH_CYC)) begin : g_bad_dwell
        $error("traffic_light_ctrl: every dwell must be in 1..2**CNT_W");
    end
    if (MIN_GREEN > GREEN_CYC) begin : g_bad_min_green
        $error("traffic_light_ctrl: MIN_GREEN must not exceed GREEN_CYC");
    end

    typedef enum logic [2:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_WALK,
        S_FLASH
    } state_t;

    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);
    // Counter value at which green has been shown for MIN_GREEN cycles.
    localparam logic [CNT_W-1:0] CUT_LIM   = CNT_W'(GREEN_CYC - MIN_GREEN);
    localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(NUM_DIR - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [DIR_W-1:0]     dir_reg, dir_next;
    logic                 phase_reg, phase_next;   // flash phase: 0 = yellow, 1 = dark
    logic                 ped_reg, ped_next;
    logic [3*NUM_DIR-1:0] light_reg, light_next;
    logic                 walk_reg, walk_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        phase_next = phase_reg;
        ped_next   = ped_reg | ped_req;

        if (flash_mode) begin
            if (state_reg != S_FLASH) begin
                state_next = S_FLASH;
                cnt_next   = FLASH_LD;
                phase_next = 1'b0;
            end else if (cnt_reg == '0) begin
                cnt_next   = FLASH_LD;
                phase_next = ~phase_reg;
            end else begin
                cnt_next   = cnt_reg - CNT_W'(1);
            end
        end else if (state_reg == S_FLASH) begin
            state_next = S_ALLRED;
            cnt_next   = ALLRED_LD;
            dir_next   = '0;
            phase_next = 1'b0;
        end else if (enable) begin
            unique case (state_reg)
                S_ALLRED: begin
                    if (cnt_reg == '0) begin
                        if (dir_reg == '0 && ped_reg) begin
                            state_next = S_WALK;
                            cnt_next   = WALK_LD;
                            ped_next   = ped_req;   // a request on this edge stays latched
                        end else begin
                            state_next = S_GREEN;
                            cnt_next   = GREEN_LD;
                        end
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                S_GREEN: begin
                    if (cnt_reg == '0 || (ped_reg && cnt_reg <= CUT_LIM)) begin
                        state_next = S_YELLOW;
                        cnt_next   = YELLOW_LD;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                S_YELLOW: begin
                    if (cnt_reg == '0) begin
                        state_next = S_ALLRED;
                        cnt_next   = ALLRED_LD;
                        dir_next   = (dir_reg == DIR_LAST) ? '0 : dir_reg + DIR_W'(1);
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                S_WALK: begin
                    if (cnt_reg == '0) begin
                        state_next = S_GREEN;
                        cnt_next   = GREEN_LD;
                        dir_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_ALLRED;
                    cnt_next   = ALLRED_LD;
                    dir_next   = '0;
                end
            endcase
        end
    end

    function automatic logic [2:0] lamp(input state_t s, input logic mine, input logic dark);
        logic [2:0] l;
        l = LAMP_RED;
        case (s)
            S_GREEN:  l = mine ? LAMP_GREEN  : LAMP_RED;
            S_YELLOW: l = mine ? LAMP_YELLOW : LAMP_RED;
            S_FLASH:  l = dark ? LAMP_DARK   : LAMP_YELLOW;
            default:  l = LAMP_RED;
        endcase
        return l;
    endfunction

    // Outputs are decoded from the next state so they register on the same edge.
    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
        assign light_next[3*gi +: 3] = lamp(state_next, dir_next == DIR_W'(gi), phase_next);
    end

    assign walk_next = (state_next == S_WALK);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_reg <= S_ALLRED;
            cnt_reg   <= ALLRED_LD;
            dir_reg   <= '0;
            phase_reg <= 1'b0;
            ped_reg   <= 1'b0;
            light_reg <= {NUM_DIR{LAMP_RED}};
            walk_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            phase_reg <= phase_next;
            ped_reg   <= ped_next;
            light_reg <= light_next;
            walk_reg  <= walk_next;
        end
    end

    assign light       = light_reg;
    assign walk        = walk_reg;
    assign active_dir  = dir_reg;
    assign ped_pending = ped_reg;

endmodule
